message_gen_unit: RTL and testbench



---
 rtl/message_gen_unit.sv | 164 ++++++++++++++++
 tb/tb_message_gen_unit.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/message_gen_unit.sv
// Message Generation Unit: accepts one activated vertex record, fetches its packed edge list
// from HBM and emits one update per edge. Define MGU_WORD_REUSE_EN to reuse a buffered edge word.
module message_gen_unit #(
   parameter int VPropWidth   = 32,
   parameter int EIndexWidth  = 32,
   parameter int EDegreeWidth = 32,
   parameter int EdgeWidth    = 32,
   parameter int AddrWidth    = 33,
   parameter int DataWidth    = 256,
   parameter int UpdateWidth  = 65,
   parameter logic [AddrWidth-1:0] EdgeBaseAddr   = 33'h1_0000_0000,
   parameter logic [AddrWidth-1:0] VertexBaseAddr = 33'h0
) (
   input  logic                                          clk,
   input  logic                                          resetn,
   input  logic [1:0]                                    control,
   input  logic [VPropWidth+EIndexWidth+EDegreeWidth:0]  MGU_data,
   input  logic                                          MGU_ready,
   output logic                                          MGU_resp,
   output logic [AddrWidth-1:0]                          read_addr,
   input  logic [DataWidth-1:0]                          read_data,
   output logic                                          start_rd,
   input  logic                                          end_rd,
   output logic [UpdateWidth-1:0]                        update,
   output logic                                          update_ready,
   input  logic                                          update_resp,
   output logic                                          busy
);

   localparam int Epw       = DataWidth / EdgeWidth;
   localparam int LaneBits  = $clog2(Epw);
   localparam int WordShift = $clog2(DataWidth / 8);
   localparam int TagWidth  = EIndexWidth - LaneBits;

   typedef enum logic [2:0] {
      IDLE, CALC, FETCH, FETCH_WAIT, EMIT, WAIT_ACK, WAIT_REL
   } state_t;

   state_t                              state;
   logic [VPropWidth-1:0]               prop_q;
   logic [EIndexWidth-1:0]              index_q;
   logic [EDegreeWidth-1:0]             degree_q;
   logic [1:0]                          ctrl_q;
   logic [VPropWidth-1:0]               new_prop;
   logic [EIndexWidth-1:0]              edge_ptr;
   logic [EDegreeWidth-1:0]             remaining;
   logic [Epw-1:0][EdgeWidth-1:0]       word_buf;
   logic [TagWidth-1:0]                 ptr_word;
   logic [EdgeWidth-1:0]                dest_id;
   logic [AddrWidth-1:0]                fetch_addr;
   logic [AddrWidth-1:0]                dest_addr;
   logic                                word_hit;
   logic                                unused_msb;

   assign unused_msb = MGU_data[VPropWidth+EIndexWidth+EDegreeWidth];

   // Address arithmetic deliberately truncates to AddrWidth so edge lists wrap around HBM.
   assign ptr_word   = edge_ptr[EIndexWidth-1:LaneBits];
   assign dest_id    = word_buf[edge_ptr[LaneBits-1:0]];
   assign fetch_addr = EdgeBaseAddr + (AddrWidth'(ptr_word) << WordShift);
   assign dest_addr  = VertexBaseAddr + (AddrWidth'(dest_id) << WordShift);

`ifdef MGU_WORD_REUSE_EN
   logic [TagWidth-1:0] tag;
   assign word_hit = (ptr_word == tag);
`else
   assign word_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state        <= IDLE;
         prop_q       <= '0;
         index_q      <= '0;
         degree_q     <= '0;
         ctrl_q       <= '0;
         new_prop     <= '0;
         edge_ptr     <= '0;
         remaining    <= '0;
         word_buf     <= '0;
         MGU_resp     <= 1'b0;
         read_addr    <= '0;
         start_rd     <= 1'b0;
         update       <= '0;
         update_ready <= 1'b0;
         busy         <= 1'b0;
`ifdef MGU_WORD_REUSE_EN
         tag          <= '0;
`endif
      end else begin
         MGU_resp <= 1'b0;
         start_rd <= 1'b0;
         case (state)
            IDLE: begin
               if (MGU_ready) begin
                  prop_q   <= MGU_data[EIndexWidth+EDegreeWidth +: VPropWidth];
                  index_q  <= MGU_data[EDegreeWidth +: EIndexWidth];
                  degree_q <= MGU_data[0 +: EDegreeWidth];
                  ctrl_q   <= control;
                  MGU_resp <= 1'b1;
                  busy     <= 1'b1;
                  state    <= CALC;
               end
            end
            CALC: begin
               edge_ptr  <= index_q;
               remaining <= degree_q;
               new_prop  <= (ctrl_q == 2'b10 && prop_q != '1) ? prop_q + VPropWidth'(1) : prop_q;
               if (degree_q == '0) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  state <= FETCH;
               end
            end
            FETCH: begin
               read_addr <= fetch_addr;
               start_rd  <= 1'b1;
               state     <= FETCH_WAIT;
            end
            FETCH_WAIT: begin
               if (end_rd) begin
                  word_buf <= read_data;
`ifdef MGU_WORD_REUSE_EN
                  tag      <= ptr_word;
`endif
                  state    <= EMIT;
               end
            end
            EMIT: begin
               update       <= UpdateWidth'({dest_addr, new_prop});
               update_ready <= 1'b1;
               state        <= WAIT_ACK;
            end
            WAIT_ACK: begin
               if (update_resp) begin
                  update_ready <= 1'b0;
                  edge_ptr     <= edge_ptr + EIndexWidth'(1);
                  remaining    <= remaining - EDegreeWidth'(1);
                  state        <= WAIT_REL;
               end
            end
            WAIT_REL: begin
               // The MPU holds its response for two cycles; only move on once it is released.
               if (!update_resp) begin
                  if (remaining == '0) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else if (word_hit) begin
                     state <= EMIT;
                  end else begin
                     state <= FETCH;
                  end
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_message_gen_unit.sv
// Self-checking bench for message_gen_unit: randomized records checked against an edge-list model.
module tb_message_gen_unit;

   localparam logic [32:0] EdgeBase = 33'h1_0000_0000;
   localparam logic [63:0] AddrMod  = 64'h2_0000_0000;

   logic         clk = 1'b0;
   logic         resetn;
   logic [1:0]   control;
   logic [96:0]  MGU_data;
   logic         MGU_ready;
   logic         MGU_resp;
   logic [32:0]  read_addr;
   logic [255:0] read_data;
   logic         start_rd;
   logic         end_rd;
   logic [64:0]  update;
   logic         update_ready;
   logic         update_resp;
   logic         busy;

   message_gen_unit dut (
      .clk(clk), .resetn(resetn), .control(control), .MGU_data(MGU_data),
      .MGU_ready(MGU_ready), .MGU_resp(MGU_resp), .read_addr(read_addr),
      .read_data(read_data), .start_rd(start_rd), .end_rd(end_rd),
      .update(update), .update_ready(update_ready), .update_resp(update_resp),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int          assertions = 0;
   int          failures = 0;
   logic [32:0] exp_rd[$];
   logic [64:0] exp_upd[$];
   logic [32:0] rd_log[$];
   logic [64:0] upd_log[$];
   int          resp_pulses;
   int          idle_cycles;
   bit          hbm_auto = 1'b1;
   int          fixed_delay = -1;
   bit          reuse;
   logic [255:0] mem_override [logic [32:0]];

   task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
      assertions++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic failNow(input string name, input logic [95:0] act);
      assertions++;
      failures++;
      $display("[TB] FAIL %s: got %0h, expected nothing", name, act);
   endtask

   // HBM contents: a hash of the byte address per lane unless a test pins a word.
   function automatic logic [255:0] mem_word(input logic [32:0] a);
      logic [255:0] w;
      if (mem_override.exists(a)) return mem_override[a];
      for (int l = 0; l < 8; l++)
         w[l*32 +: 32] = (a[31:0] * 32'h9E37_79B1) ^ (32'(l) * 32'h85EB_CA6B) ^ {31'h0, a[32]};
      return w;
   endfunction

   function automatic void buildModel(input logic [31:0] prop, input logic [31:0] idx,
                                      input logic [31:0] deg, input logic [1:0] ctrl);
      logic [31:0]  np, e, w, prev_w, dest;
      logic [32:0]  a;
      logic [255:0] word;
      np = (ctrl == 2'b10) ? ((prop == 32'hFFFF_FFFF) ? prop : prop + 32'd1) : prop;
      prev_w = '0;
      for (longint k = 0; k < longint'(deg); k++) begin
         e = idx + 32'(k);
         w = e / 32'd8;
         a = 33'((64'(EdgeBase) + 64'(w) * 64'd32) % AddrMod);
         if (!reuse || k == 0 || w != prev_w) exp_rd.push_back(a);
         prev_w = w;
         word = mem_word(a);
         dest = word[(e % 32'd8) * 32 +: 32];
         exp_upd.push_back({33'((64'(dest) * 64'd32) % AddrMod), np});
      end
   endfunction

   // Per-cycle compare process against the model queues and the handshake rules.
   bit          prev_ready = 1'b0, prev_start = 1'b0, prev_mresp = 1'b0;
   logic        resp_edge;
   logic [64:0] held;
   always @(posedge clk) begin
      resp_edge = update_resp;
      #1;
      if (!resetn) begin
         prev_ready = 1'b0;
         prev_start = 1'b0;
         prev_mresp = 1'b0;
      end else begin
         if (prev_ready && resp_edge) checkOutput("ready_drop_after_resp", 96'(update_ready), 96'd0);
         if (update_ready && !prev_ready) begin
            checkOutput("resp_low_at_new_update", 96'(resp_edge), 96'd0);
            held = update;
            upd_log.push_back(update);
            if (exp_upd.size() == 0) failNow("unexpected_update", 96'(update));
            else checkOutput("update_value", 96'(update), 96'(exp_upd.pop_front()));
         end else if (update_ready) begin
            checkOutput("update_stable", 96'(update), 96'(held));
         end
         if (start_rd) begin
            checkOutput("start_rd_pulse", 96'(prev_start), 96'd0);
            rd_log.push_back(read_addr);
            if (exp_rd.size() == 0) failNow("unexpected_read", 96'(read_addr));
            else checkOutput("read_addr", 96'(read_addr), 96'(exp_rd.pop_front()));
         end
         if (MGU_resp) begin
            checkOutput("mgu_resp_pulse", 96'(prev_mresp), 96'd0);
            resp_pulses++;
         end
         prev_ready = update_ready;
         prev_start = start_rd;
         prev_mresp = MGU_resp;
      end
   end

   initial begin
      int d;
      update_resp = 1'b0;
      forever begin
         @(negedge clk);
         if (update_ready) begin
            d = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 4));
            repeat (d) @(negedge clk);
            update_resp = 1'b1;
            repeat (2) @(negedge clk);
            update_resp = 1'b0;
         end
      end
   end

   initial begin
      logic [32:0] a;
      end_rd = 1'b0;
      read_data = '0;
      forever begin
         @(negedge clk);
         if (start_rd && hbm_auto) begin
            a = read_addr;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            read_data = mem_word(a);
            end_rd = 1'b1;
            @(negedge clk);
            end_rd = 1'b0;
            read_data = '0;
         end
      end
   end

   task automatic checkReset(input string tag);
      checkOutput({tag, "_busy"}, 96'(busy), 96'd0);
      checkOutput({tag, "_mgu_resp"}, 96'(MGU_resp), 96'd0);
      checkOutput({tag, "_start_rd"}, 96'(start_rd), 96'd0);
      checkOutput({tag, "_read_addr"}, 96'(read_addr), 96'd0);
      checkOutput({tag, "_update_ready"}, 96'(update_ready), 96'd0);
      checkOutput({tag, "_update"}, 96'(update), 96'd0);
   endtask

   task automatic applyStimulus(input logic [31:0] prop, input logic [31:0] idx,
                                input logic [31:0] deg, input logic [1:0] ctrl);
      int cyc, n_rd, n_upd;
      exp_rd.delete(); exp_upd.delete(); rd_log.delete(); upd_log.delete();
      resp_pulses = 0;
      buildModel(prop, idx, deg, ctrl);
      n_rd = exp_rd.size();
      n_upd = exp_upd.size();
      @(negedge clk);
      control = ctrl;
      MGU_data = {1'b1, prop, idx, deg};
      MGU_ready = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!MGU_resp && cyc < 20);
      MGU_ready = 1'b0;
      control = ~ctrl;
      if (!MGU_resp) failNow("accept_timeout", 96'(cyc));
      idle_cycles = 0;
      while (busy && idle_cycles < 5000) begin
         @(negedge clk);
         idle_cycles++;
      end
      checkOutput("idle_reached", 96'(busy), 96'd0);
      repeat (2) @(negedge clk);
      checkOutput("read_count", 96'(rd_log.size()), 96'(n_rd));
      checkOutput("update_count", 96'(upd_log.size()), 96'(n_upd));
      checkOutput("resp_pulses", 96'(resp_pulses), 96'd1);
   endtask

   task automatic resetMidFetch();
      int cyc;
      hbm_auto = 1'b0;
      exp_rd.delete(); exp_upd.delete(); rd_log.delete(); upd_log.delete();
      buildModel(32'd20, 32'd16, 32'd5, 2'b10);
      @(negedge clk);
      control = 2'b10;
      MGU_data = {1'b0, 32'd20, 32'd16, 32'd5};
      MGU_ready = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         if (MGU_resp) MGU_ready = 1'b0;
         cyc++;
      end while (!start_rd && cyc < 20);
      MGU_ready = 1'b0;
      checkOutput("reset_reached_fetch", 96'(start_rd), 96'd1);
      @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      read_data = mem_word(33'h1_0000_0040);
      end_rd = 1'b1;
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      end_rd = 1'b0;
      read_data = '0;
      exp_rd.delete(); exp_upd.delete();
      repeat (4) begin
         @(negedge clk);
         checkReset("after_reset");
      end
      hbm_auto = 1'b1;
   endtask

   initial begin
      logic [64:0] u;
`ifdef MGU_WORD_REUSE_EN
      reuse = 1'b1;
`else
      reuse = 1'b0;
`endif
      resetn = 1'b0;
      MGU_ready = 1'b0;
      MGU_data = '0;
      control = 2'b00;
      repeat (3) @(negedge clk);
      checkReset("reset");
      resetn = 1'b1;

      applyStimulus(32'd10, 32'd0, 32'd0, 2'b10);
      checkOutput("deg0_idle_cycles", 96'(idle_cycles), 96'd1);
      checkOutput("deg0_reads", 96'(rd_log.size()), 96'd0);

      mem_override[EdgeBase] = {160'h0, 32'd2, 32'd9, 32'd7};
      applyStimulus(32'd5, 32'd0, 32'd3, 2'b10);
      u = upd_log[0]; checkOutput("lit_upd0", 96'(u), 96'({33'hE0, 32'd6}));
      u = upd_log[1]; checkOutput("lit_upd1", 96'(u), 96'({33'h120, 32'd6}));
      u = upd_log[2]; checkOutput("lit_upd2", 96'(u), 96'({33'h40, 32'd6}));
      checkOutput("lit_reads3", 96'(rd_log.size()), reuse ? 96'd1 : 96'd3);

      applyStimulus($urandom, 32'd6, 32'd4, 2'b01);
      checkOutput("lit_first_addr", 96'(rd_log[0]), 96'(EdgeBase));
      checkOutput("lit_last_addr", 96'(rd_log[rd_log.size()-1]), 96'(33'h1_0000_0020));
      checkOutput("lit_reads_cross", 96'(rd_log.size()), reuse ? 96'd2 : 96'd4);

      applyStimulus(32'hFFFF_FFFF, $urandom, 32'd2, 2'b10);
      u = upd_log[0]; checkOutput("lit_saturate", 96'(u[31:0]), 96'(32'hFFFF_FFFF));
      applyStimulus(32'd3, $urandom, 32'd2, 2'b00);
      u = upd_log[0]; checkOutput("lit_passthru", 96'(u[31:0]), 96'd3);

      fixed_delay = 10;
      applyStimulus($urandom, $urandom, 32'd3, 2'b10);
      fixed_delay = -1;

      applyStimulus($urandom, 32'hFFFF_FFFC, 32'd9, 2'b10);

      resetMidFetch();
      applyStimulus(32'd42, 32'd13, 32'd5, 2'b10);

      for (int i = 0; i < 30; i++) begin
         logic [31:0] p, x, dg;
         logic [1:0]  c;
         p  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
         x  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
         dg = 32'($urandom_range(0, 20));
         c  = 2'($urandom_range(0, 3));
         applyStimulus(p, x, dg, c);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

   initial begin
      #900_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
